// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte strobes for uart_rx
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_err;
    logic       o_busy;

    // Line driver side: drives the serial line, observes the received bytes.
    modport master (
        output i_rx,
        input  o_data,
        input  o_vld,
        input  o_err,
        input  o_busy
    );

    // Receiver side.
    modport slave (
        input  i_rx,
        output o_data,
        output o_vld,
        output o_err,
        output o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver with mid-bit sampling
module uart_rx #(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    uart_rx_if.slave bus
);
    localparam int DIV = FREQ / RATE;
    localparam int TW  = $clog2(DIV + 1);
    localparam logic [TW-1:0] HALF = TW'(DIV / 2);
    localparam logic [TW-1:0] FULL = TW'(DIV);
    localparam logic [TW-1:0] ONE  = TW'(1);

    // The half-bit offset and the timer reload need at least a few clocks per bit.
    if (DIV < 4) begin : g_div_check
        $error("uart_rx: FREQ/RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic [1:0]  sync_q;
    logic        rx_s;
    logic [TW-1:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        vld_q;
    logic        err_q;
    logic        busy_q;

    assign rx_s       = sync_q[1];
    assign bus.o_data = data_q;
    assign bus.o_vld  = vld_q;
    assign bus.o_err  = err_q;
    assign bus.o_busy = busy_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.i_rx};
        end
    end

    // Frame FSM: the timer counts down and a bit is sampled on the cycle it reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        timer  <= HALF;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (timer == ONE) begin
                        if (rx_s) begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state  <= IDLE;
                            timer  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            timer   <= FULL;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                DATA: begin
                    if (timer == ONE) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        timer   <= FULL;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                STOP: begin
                    if (timer == ONE) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                            data_q <= shift_q;
                            vld_q  <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line must not be mistaken for further start bits.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 25 clocks per bit
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_strobe = 1'b0;

    typedef struct {
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t        vq[$];
    int unsigned eq[$];

    uart_rx_if u_if ();

    uart_rx #(
        .FREQ(50_000_000),
        .RATE(2_000_000)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Drives one 8N1 frame starting at the current negedge; leaves the line at the stop level.
    // Valid frames are expected to strobe 240 negedges after the start bit is driven
    // (3 cycles of synchronizer/FSM latency, then 12 + 9*25 to the stop sample).
    task automatic send(input logic [7:0] b, input int per, input logic stop, input bit track);
        logic [9:0]  fr;
        int unsigned start;
        exp_t        e;
        fr    = {stop, b, 1'b0};
        start = cyc;
        if (track) begin
            if (stop) begin
                e.data = b;
                e.at   = start + 240;
                vq.push_back(e);
            end else begin
                eq.push_back(start + 240);
            end
        end
        for (int i = 0; i < 10; i++) begin
            u_if.i_rx = fr[i];
            repeat (per) @(negedge clk);
        end
    endtask

    // Scoreboard monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (u_if.o_vld || u_if.o_err) begin
                chk("strobe_overlap", {31'b0, u_if.o_vld & u_if.o_err}, 32'd0);
                chk("strobe_repeat", {31'b0, prev_strobe}, 32'd0);
            end
            if (u_if.o_vld) begin
                if (vq.size() == 0) begin
                    chk("vld_unexpected", 32'd1, 32'd0);
                end else begin
                    e = vq.pop_front();
                    chk("vld_data", {24'b0, u_if.o_data}, {24'b0, e.data});
                    chk("vld_cycle", cyc, e.at);
                end
            end
            if (u_if.o_err) begin
                if (eq.size() == 0) begin
                    chk("err_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("err_cycle", cyc, eq.pop_front());
                end
            end
            prev_strobe <= u_if.o_vld | u_if.o_err;
        end else begin
            prev_strobe <= 1'b0;
        end
    end

    initial begin
        int unsigned c;
        u_if.i_rx = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'b0, u_if.o_data}, 32'h00);
        chk("rst_vld", {31'b0, u_if.o_vld}, 32'd0);
        chk("rst_err", {31'b0, u_if.o_err}, 32'd0);
        chk("rst_busy", {31'b0, u_if.o_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte at nominal rate.
        send(8'hA5, 25, 1'b1, 1'b1);
        repeat (30) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send(8'h00, 25, 1'b1, 1'b1);
        send(8'hFF, 25, 1'b1, 1'b1);
        send(8'h55, 25, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        chk("b2b_drained", vq.size(), 32'd0);

        // Short low glitch rejected at the mid-start check.
        c = cyc;
        u_if.i_rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_hi", {31'b0, u_if.o_busy}, 32'd1);
        @(negedge clk);
        u_if.i_rx = 1'b1;
        while (cyc < c + 16) @(negedge clk);
        chk("glitch_busy_lo", {31'b0, u_if.o_busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Framing error followed by a long break.
        send(8'h3C, 25, 1'b0, 1'b1);
        repeat (1000) @(negedge clk);
        chk("ferr_data_kept", {24'b0, u_if.o_data}, 32'h55);
        chk("ferr_busy_break", {31'b0, u_if.o_busy}, 32'd1);
        u_if.i_rx = 1'b1;
        c = cyc;
        @(negedge clk);
        chk("ferr_busy_hold", {31'b0, u_if.o_busy}, 32'd1);
        while (cyc < c + 4) @(negedge clk);
        chk("ferr_busy_rel", {31'b0, u_if.o_busy}, 32'd0);
        chk("ferr_drained", eq.size(), 32'd0);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 of 8'h81.
        u_if.i_rx = 1'b0;
        repeat (25) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.i_rx = (i == 0);
            repeat (25) @(negedge clk);
        end
        u_if.i_rx = 1'b0;
        repeat (10) @(negedge clk);
        rst_n     = 1'b0;
        u_if.i_rx = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, u_if.o_busy}, 32'd0);
        chk("abort_data", {24'b0, u_if.o_data}, 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h7E, 25, 1'b1, 1'b1);
        repeat (30) @(negedge clk);

        // Rate tolerance: slow and fast transmitters.
        send(8'hC3, 24, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        send(8'hC3, 26, 1'b1, 1'b1);
        repeat (300) @(negedge clk);

        chk("sb_vld_empty", vq.size(), 32'd0);
        chk("sb_err_empty", eq.size(), 32'd0);
        chk("final_data", {24'b0, u_if.o_data}, 32'hC3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
